// File: rtl/ram8_clr.sv
// ---------------------------------------------------------------------------
// Module      : ram8_clr
// Description : Demux-loaded word register bank with registered read port and
//               a one-word-per-cycle clear sequencer.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ram8_clr #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [AW-1:0]    address,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             busy
);

  localparam logic [0:0]    c_idle  = 1'b0;
  localparam logic [0:0]    c_sweep = 1'b1;
  localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);

  logic [0:0]       r_state;
  logic [AW-1:0]    r_idx;
  logic [WIDTH-1:0] r_mem [DEPTH];

  // The read samples the pre-edge array, so a same-edge write shows up one edge later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_idle;
      r_idx   <= '0;
      out     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      out <= r_mem[address];
      case (r_state)
        c_idle: begin
          if (clr) begin
            r_state <= c_sweep;
            r_idx   <= '0;
          end else if (load) begin
            r_mem[address] <= in;
          end
        end
        c_sweep: begin
          r_mem[r_idx] <= '0;
          r_idx        <= r_idx + 1'b1;
          if (r_idx == c_last) begin
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign busy = (r_state == c_sweep);

endmodule

`default_nettype wire

// File: tb/tb_ram8_clr.sv
// ---------------------------------------------------------------------------
// Module      : tb_ram8_clr
// Description : Directed self-checking bench for ram8_clr.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram8_clr;

  logic        clk;
  logic        reset_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic        clr;
  logic [15:0] out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  ram8_clr #(.WIDTH(16), .DEPTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (in),
    .load    (load),
    .address (address),
    .clr     (clr),
    .out     (out),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    tick();
    load    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
    address = a;
    tick();
    check(tag, out, exp);
  endtask

  initial begin
    int         cnt;
    logic [11:0] pat;

    reset_n = 1'b0;
    load    = 1'b1;
    in      = 16'hFFFF;
    address = 3'd0;
    clr     = 1'b0;

    // Reset held for two edges with a load pending
    repeat (2) begin
      tick();
      check("rst_out", out, 16'h0000);
      check("rst_busy", {15'd0, busy}, 16'h0000);
    end
    load    = 1'b0;
    reset_n = 1'b1;
    check("post_rst_busy", {15'd0, busy}, 16'h0000);
    for (int a = 0; a < 8; a++) rd("rst_word", 3'(a), 16'h0000);

    // Demux write and readback
    wr(3'd3, 16'h1234);
    wr(3'd5, 16'hABCD);
    for (int a = 0; a < 8; a++)
      rd("readback", 3'(a), (a == 3) ? 16'h1234 : (a == 5) ? 16'hABCD : 16'h0000);

    // Read-before-write on the same address
    address = 3'd3;
    tick();
    in   = 16'h5555;
    load = 1'b1;
    tick();
    load = 1'b0;
    check("rbw_old", out, 16'h1234);
    tick();
    check("rbw_new", out, 16'h5555);

    // Clear sweep with writes attempted late in the sweep
    for (int a = 0; a < 8; a++) wr(3'(a), 16'h00FF + 16'(a));
    rd("fill_chk", 3'd7, 16'h0106);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_busy_rise", {15'd0, busy}, 16'h0001);
    cnt = 1;
    while (busy && cnt < 20) begin
      if (cnt >= 4) begin
        address = 3'd2;
        in      = 16'hBEEF;
        load    = 1'b1;
      end
      tick();
      if (busy) cnt++;
    end
    load = 1'b0;
    check("clr_busy_len", 16'(cnt), 16'd8);
    for (int a = 0; a < 8; a++) rd("swept_word", 3'(a), 16'h0000);
    wr(3'd4, 16'h4444);
    rd("post_clr_load", 3'd4, 16'h4444);

    // Clear and load in the same idle cycle
    wr(3'd6, 16'h1111);
    address = 3'd6;
    in      = 16'h7777;
    load    = 1'b1;
    clr     = 1'b1;
    tick();
    load    = 1'b0;
    clr     = 1'b0;
    check("coll_busy", {15'd0, busy}, 16'h0001);
    repeat (8) tick();
    check("coll_idle", {15'd0, busy}, 16'h0000);
    rd("coll_word6", 3'd6, 16'h0000);
    rd("coll_word4", 3'd4, 16'h0000);

    // Held clear: eight busy, one idle, then a fresh sweep
    clr = 1'b1;
    pat = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      pat[11 - i] = busy;
    end
    clr = 1'b0;
    check("held_clr_pattern", {4'd0, pat}, 16'h0FF7);
    repeat (6) tick();
    check("held_clr_done", {15'd0, busy}, 16'h0000);

    // Asynchronous reset in the middle of a sweep
    for (int a = 0; a < 8; a++) wr(3'(a), 16'hA0A0 + 16'(a));
    address = 3'd7;
    clr     = 1'b1;
    tick();
    clr     = 1'b0;
    repeat (3) tick();
    check("mid_busy_pre", {15'd0, busy}, 16'h0001);
    check("mid_out_pre", out, 16'hA0A7);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {15'd0, busy}, 16'h0000);
    check("mid_rst_out", out, 16'h0000);
    tick();
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) rd("mid_rst_word", 3'(a), 16'h0000);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      tick();
    end
    check("mid_rst_resweep", 16'(cnt), 16'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
